// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the register-file write port. Merges the in-order
// MEM/WB result with buffered multi-cycle (mul/div) results, one write per
// cycle, and tracks pending multi-cycle destinations to drive the decode
// hazard stall.
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    input  logic          mc_valid,
    input  logic [4:0]    mc_rd,
    input  logic [31:0]   mc_data,
    output logic          mc_ready,
    input  logic          mc_issue,
    input  logic [4:0]    mc_issue_rd,
    input  logic [4:0]    read_reg1,
    input  logic [4:0]    read_reg2,
    input  logic [4:0]    dec_rd,
    input  logic          dec_reg_write,
    output logic          hazard_stall,
    output logic          do_reg_write,
    output logic [4:0]    do_write_reg,
    output logic [31:0]   write_data,
    output logic [AW:0]   fifo_count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Multi-cycle result FIFO storage
    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    // Pending scoreboard for multi-cycle destinations
    logic [31:0]   pending_q, pending_d;

    // Write-port output registers
    logic          we_q, we_d;
    logic [4:0]    wr_q, wr_d;
    logic [31:0]   wd_q, wd_d;

    logic          push, pop, wb_win;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // Ready depends only on registered occupancy, never on the same-cycle pop.
    assign mc_ready  = (count_q != FULL_CNT);
    // Writes to x0 are accepted on the handshake but never stored.
    assign push      = mc_valid && mc_ready && (mc_rd != 5'd0);
    assign wb_win    = wb_valid && (wb_rd != 5'd0);
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    assign hazard_stall = pending_q[read_reg1] | pending_q[read_reg2] |
                          (dec_reg_write & pending_q[dec_rd]);

    assign do_reg_write = we_q;
    assign do_write_reg = wr_q;
    assign write_data   = wd_q;
    assign fifo_count   = count_q;

    // Arbitrate the write port, update occupancy and the scoreboard
    always_comb begin
        we_d      = 1'b0;
        wr_d      = wr_q;
        wd_d      = wd_q;
        pop       = 1'b0;
        pending_d = pending_q;
        count_d   = count_q;

        if (wb_win) begin
            we_d = 1'b1;
            wr_d = wb_rd;
            wd_d = wb_data;
        end else if (count_q != '0) begin
            pop                = 1'b1;
            we_d               = 1'b1;
            wr_d               = head_rd;
            wd_d               = head_data;
            pending_d[head_rd] = 1'b0;
        end

        // A new issue to the same register overrides the clear from the pop.
        if (mc_issue && (mc_issue_rd != 5'd0)) begin
            pending_d[mc_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO entry write on push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mc_rd;
            fifo_data_q[wr_ptr_q] <= mc_data;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            wr_q      <= '0;
            wd_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q   <= count_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            wr_q      <= wr_d;
            wd_q      <= wd_d;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked against a queue-based
// behavioural model every cycle.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          mc_valid;
    logic [4:0]    mc_rd;
    logic [31:0]   mc_data;
    logic          mc_ready;
    logic          mc_issue;
    logic [4:0]    mc_issue_rd;
    logic [4:0]    read_reg1;
    logic [4:0]    read_reg2;
    logic [4:0]    dec_rd;
    logic          dec_reg_write;
    logic          hazard_stall;
    logic          do_reg_write;
    logic [4:0]    do_write_reg;
    logic [31:0]   write_data;
    logic [AW:0]   fifo_count;

    writeback_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
        .hazard_stall(hazard_stall),
        .do_reg_write(do_reg_write), .do_write_reg(do_write_reg),
        .write_data(write_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend = '0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_wr   = '0;
    logic [31:0] m_wd   = '0;
    logic        m_full;
    ent_t        m_e;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_pend = '0;
            m_we   = 1'b0;
            m_wr   = '0;
            m_wd   = '0;
        end else begin
            assert (!(wb_valid && wb_rd != 0 && m_pend[wb_rd]))
                else $error("protocol: pipeline write to pending register %0d", wb_rd);
            m_full = (mq.size() == DEPTH);
            if (wb_valid && wb_rd != 0) begin
                m_we = 1'b1; m_wr = wb_rd; m_wd = wb_data;
            end else if (mq.size() > 0) begin
                m_e = mq.pop_front();
                m_we = 1'b1; m_wr = m_e.rd; m_wd = m_e.data;
                m_pend[m_e.rd] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (mc_valid && !m_full && mc_rd != 0) begin
                m_e.rd = mc_rd; m_e.data = mc_data;
                mq.push_back(m_e);
            end
            if (mc_issue && mc_issue_rd != 0) m_pend[mc_issue_rd] = 1'b1;
            m_pend[0] = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("do_reg_write", {31'b0, do_reg_write}, {31'b0, m_we});
        chk("do_write_reg", {27'b0, do_write_reg}, {27'b0, m_wr});
        chk("write_data",   write_data, m_wd);
        chk("fifo_count",   {29'b0, fifo_count}, mq.size());
        chk("mc_ready",     {31'b0, mc_ready}, {31'b0, mq.size() != DEPTH});
        chk("hazard_stall", {31'b0, hazard_stall},
            {31'b0, m_pend[read_reg1] | m_pend[read_reg2] | (dec_reg_write & m_pend[dec_rd])});
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        mc_issue = 0; mc_issue_rd = 0;
        read_reg1 = 0; read_reg2 = 0; dec_rd = 0; dec_reg_write = 0;
    endtask

    logic [4:0] oq[$];
    logic [4:0] tmp_rd;

    initial begin
        reset = 1'b0;
        idle();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_we", {31'b0, do_reg_write}, 0);
        chk("rst_cnt", {29'b0, fifo_count}, 0);
        chk("rst_ready", {31'b0, mc_ready}, 1);

        // pipeline only
        wb_valid = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
        step();
        chk("wb_we", {31'b0, do_reg_write}, 1);
        chk("wb_rd", {27'b0, do_write_reg}, 7);
        chk("wb_data", write_data, 32'hDEADBEEF);
        wb_rd = 0; wb_data = 32'h1234;
        step();
        chk("wb_x0_we", {31'b0, do_reg_write}, 0);
        chk("wb_x0_hold", write_data, 32'hDEADBEEF);
        wb_valid = 0;

        // contention: pipeline holds the port for 3 cycles
        wb_valid = 1; wb_rd = 3; wb_data = 32'hA;
        mc_valid = 1; mc_rd = 9; mc_data = 32'h11;
        step();
        mc_valid = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            chk("cont_rd", {27'b0, do_write_reg}, 3);
            chk("cont_cnt", {29'b0, fifo_count}, 1);
            if (i == 2) wb_valid = 0;
            step();
        end
        chk("cont_mc_rd", {27'b0, do_write_reg}, 9);
        chk("cont_mc_data", write_data, 32'h11);
        chk("cont_cnt0", {29'b0, fifo_count}, 0);

        // full FIFO
        wb_valid = 1; wb_rd = 6; wb_data = 32'h66;
        for (int unsigned i = 1; i <= 4; i++) begin
            mc_valid = 1; mc_rd = 5'(i); mc_data = 32'h100 + i;
            step();
        end
        chk("full_cnt", {29'b0, fifo_count}, 4);
        chk("full_ready", {31'b0, mc_ready}, 0);
        mc_rd = 5; mc_data = 32'h105;
        step();
        chk("full_held", {29'b0, fifo_count}, 4);
        wb_valid = 0; mc_valid = 0;
        for (int unsigned i = 1; i <= 4; i++) begin
            step();
            chk("drain_rd", {27'b0, do_write_reg}, i);
            chk("drain_data", write_data, 32'h100 + i);
            if (i == 1) chk("drain_ready", {31'b0, mc_ready}, 1);
        end

        // scoreboard
        mc_issue = 1; mc_issue_rd = 12;
        step();
        mc_issue = 0; read_reg2 = 12;
        #1 chk("sb_rs2", {31'b0, hazard_stall}, 1);
        read_reg2 = 0; dec_rd = 12; dec_reg_write = 1;
        #1 chk("sb_waw", {31'b0, hazard_stall}, 1);
        dec_reg_write = 0;
        #1 chk("sb_nowrite", {31'b0, hazard_stall}, 0);
        dec_rd = 0;
        mc_issue = 1; mc_issue_rd = 0; read_reg1 = 0;
        step();
        mc_issue = 0;
        #1 chk("sb_x0", {31'b0, hazard_stall}, 0);
        read_reg2 = 12; mc_valid = 1; mc_rd = 12; mc_data = 32'h1200;
        step();
        mc_valid = 0;
        #1 chk("sb_inflight", {31'b0, hazard_stall}, 1);
        step();
        chk("sb_wr12", {27'b0, do_write_reg}, 12);
        chk("sb_clear", {31'b0, hazard_stall}, 0);
        read_reg2 = 0;

        // set/clear collision
        mc_issue = 1; mc_issue_rd = 12;
        step();
        mc_issue = 0; mc_valid = 1; mc_rd = 12; mc_data = 32'h1201;
        step();
        mc_valid = 0; mc_issue = 1; mc_issue_rd = 12; read_reg1 = 12;
        step();
        mc_issue = 0;
        chk("coll_wr", {27'b0, do_write_reg}, 12);
        chk("coll_data", write_data, 32'h1201);
        #1 chk("coll_stall", {31'b0, hazard_stall}, 1);

        // reset mid-run
        read_reg1 = 0;
        mc_issue = 1; mc_issue_rd = 5;
        step();
        mc_issue = 0;
        wb_valid = 1; wb_rd = 6; wb_data = 32'h77;
        for (int unsigned i = 0; i < 3; i++) begin
            mc_valid = 1; mc_rd = 5'(20 + i); mc_data = 32'h200 + i;
            step();
        end
        mc_valid = 0; read_reg1 = 5;
        #1 chk("pre_rst_cnt", {29'b0, fifo_count}, 3);
        chk("pre_rst_stall", {31'b0, hazard_stall}, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we", {31'b0, do_reg_write}, 0);
        chk("mid_rst_cnt", {29'b0, fifo_count}, 0);
        chk("mid_rst_ready", {31'b0, mc_ready}, 1);
        chk("mid_rst_stall", {31'b0, hazard_stall}, 0);
        idle();
        @(posedge clk);
        #3 reset = 1'b0;
        step();

        // randomized traffic
        for (int unsigned c = 0; c < 1500; c++) begin
            int unsigned wbp;
            wbp = (c < 700) ? 70 : 25;
            mc_issue = ($urandom_range(0, 3) == 0);
            mc_issue_rd = 5'($urandom_range(0, 31));
            mc_valid = 0; mc_rd = 0; mc_data = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (oq.size() > 0 && $urandom_range(0, 7) != 0) begin
                    mc_valid = 1; mc_rd = oq[0];
                    if (mq.size() != DEPTH) tmp_rd = oq.pop_front();
                end else if ($urandom_range(0, 3) == 0) begin
                    mc_valid = 1; mc_rd = 0;
                end
            end
            if (mc_issue && mc_issue_rd != 0) oq.push_back(mc_issue_rd);
            wb_valid = ($urandom_range(0, 99) < wbp);
            wb_data = $urandom;
            wb_rd = 5'($urandom_range(0, 31));
            if (m_pend[wb_rd]) wb_rd = 5'($urandom_range(0, 31));
            if (m_pend[wb_rd]) wb_valid = 0;
            read_reg1 = 5'($urandom_range(0, 31));
            read_reg2 = 5'($urandom_range(0, 31));
            dec_rd = 5'($urandom_range(0, 31));
            dec_reg_write = $urandom_range(0, 1) == 1;
            step();
        end

        idle();
        repeat (20) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
